// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage with a configurable number of wait states.
// It keeps the initiator stalled until the access completes and pulses done_o for one cycle.
module data_mem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] data_o,
  output logic        stallreq_o,
  output logic        done_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_idx;
  logic [31:0]       cap_data;
  logic [3:0]        cap_sel;

  logic              commit;
  logic              c_we;
  logic [ADDR_W-1:0] c_idx;
  logic [31:0]       c_data;
  logic [3:0]        c_sel;

  logic [31:0]       mem [DEPTH];

  // Only the word-index bits address the array; the rest alias.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cap_we   <= 1'b0;
      cap_idx  <= '0;
      cap_data <= '0;
      cap_sel  <= '0;
      data_o   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == IDLE && ce_i) begin
        cap_we   <= we_i;
        cap_idx  <= addr_i[ADDR_W+1:2];
        cap_data <= data_i;
        cap_sel  <= sel_i;
      end
      if (commit && !c_we)
        data_o <= mem[c_idx];
    end
  end

  // The commit fields come from the live inputs only when a zero-wait access
  // completes on the same edge that accepts it; otherwise from the captured copy.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    commit  = 1'b0;
    c_we    = cap_we;
    c_idx   = cap_idx;
    c_data  = cap_data;
    c_sel   = cap_sel;
    case (state)
      IDLE: begin
        if (ce_i) begin
          cnt_n = WAIT_INIT;
          if (WAIT_CYCLES == 0) begin
            state_n = DONE;
            commit  = 1'b1;
            c_we    = we_i;
            c_idx   = addr_i[ADDR_W+1:2];
            c_data  = data_i;
            c_sel   = sel_i;
          end else begin
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        if (!ce_i) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - 4'd1;
          if (cnt == 4'd1) begin
            state_n = DONE;
            commit  = 1'b1;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Storage is deliberately not reset; rst only blocks an in-flight commit.
  always_ff @(posedge clk) begin
    if (commit && c_we && !rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (c_sel[i])
          mem[c_idx][8*i +: 8] <= c_data[8*i +: 8];
      end
    end
  end

  assign done_o     = (state == DONE);
  assign stallreq_o = ce_i && (state != DONE);

endmodule
